// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle between a burst initiator and a responder.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [LEN_WIDTH-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [1:0]            awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [LEN_WIDTH-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 initiator: one INCR write or read burst per command,
// with write data streamed in and read data streamed out.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  rlast_o,
    output logic                  done_o,
    output logic [1:0]            resp_o,
    axi_burst_master_if.master    axi
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, AW_REQ, W_DATA, B_RESP, AR_REQ, R_DATA} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [1:0]            resp_q, resp_d;
    logic                  done_q, done_d;

    logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic unused_ids;

    // AXI responses are ordered OKAY < EXOKAY < SLVERR < DECERR, so the worst is the max.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign cmd_fire = (state_q == IDLE)   && cmd_valid_i;
    assign aw_fire  = (state_q == AW_REQ) && axi.awready;
    assign w_fire   = (state_q == W_DATA) && wvalid_i && axi.wready;
    assign b_fire   = (state_q == B_RESP) && axi.bvalid;
    assign ar_fire  = (state_q == AR_REQ) && axi.arready;
    assign r_fire   = (state_q == R_DATA) && axi.rvalid && rready_i;

    // Fixed request attributes: single ID, full-width beats, INCR bursts.
    assign axi.awid    = ID_WIDTH'(AXI_ID);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = 3'($clog2(STRB_WIDTH));
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0011;
    assign axi.awprot  = 3'b000;
    assign axi.awqos   = 4'b0000;
    assign axi.arid    = ID_WIDTH'(AXI_ID);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = 3'($clog2(STRB_WIDTH));
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0011;
    assign axi.arprot  = 3'b000;
    assign axi.arqos   = 4'b0000;

    assign axi.wdata = wdata_i;
    assign axi.wstrb = wstrb_i;
    assign rdata_o   = axi.rdata;
    assign done_o    = done_q;
    assign resp_o    = resp_q;

    // Response IDs are not needed: only one burst is ever outstanding.
    assign unused_ids = ^{axi.bid, axi.rid};

    // State register; async reset drops every valid at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: one handshake advances each phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = cmd_we_i ? AW_REQ : AR_REQ;
            AW_REQ:  if (aw_fire) state_d = W_DATA;
            W_DATA:  if (w_fire && (count_q == len_q)) state_d = B_RESP;
            B_RESP:  if (b_fire) state_d = IDLE;
            AR_REQ:  if (ar_fire) state_d = R_DATA;
            R_DATA:  if (r_fire && axi.rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: streams are wired straight through only in their data phase.
    always_comb begin
        cmd_ready_o = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        wready_o    = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        rvalid_o    = 1'b0;
        rlast_o     = 1'b0;
        case (state_q)
            IDLE:   cmd_ready_o = 1'b1;
            AW_REQ: axi.awvalid = 1'b1;
            W_DATA: begin
                axi.wvalid = wvalid_i;
                axi.wlast  = (count_q == len_q);
                wready_o   = axi.wready;
            end
            B_RESP: axi.bready = 1'b1;
            AR_REQ: axi.arvalid = 1'b1;
            R_DATA: begin
                axi.rready = rready_i;
                rvalid_o   = axi.rvalid;
                rlast_o    = axi.rlast;
            end
            default: ;
        endcase
    end

    // Burst bookkeeping: latch command, count beats, accumulate response, flag completion.
    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        if (cmd_fire) begin
            addr_d  = cmd_addr_i & ~ADDR_MASK;
            len_d   = cmd_len_i;
            count_d = '0;
            resp_d  = 2'b00;
        end
        if (w_fire || r_fire) count_d = count_q + LEN_WIDTH'(1);
        if (r_fire) begin
            resp_d = worst_resp(resp_q, axi.rresp);
            done_d = axi.rlast;
        end
        if (b_fire) begin
            resp_d = axi.bresp;
            done_d = 1'b1;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            resp_q  <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master with a small AXI RAM responder.
module tb_axi_burst_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] rdata;
    logic        rvalid, rready = 1'b0, rlast, done;
    logic [1:0]  resp;

    axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .LEN_WIDTH(8)) axi();

    axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .LEN_WIDTH(8), .AXI_ID(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready), .rlast_o(rlast),
        .done_o(done), .resp_o(resp), .axi(axi)
    );

    always #5 clk = ~clk;

    // ---------------- responder (AXI RAM, 256 words) ----------------
    logic [31:0] mem [0:255];
    logic        aw_act;
    logic [15:0] waddr_q, raddr_q;
    logic [8:0]  rrem_q;
    logic        bvalid_q;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    assign axi.awready = 1'b1;
    assign axi.wready  = aw_act;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_cfg;
    assign axi.bid     = '0;
    assign axi.arready = (rrem_q == 9'd0) && !aw_act;
    assign axi.rvalid  = (rrem_q != 9'd0);
    assign axi.rdata   = mem[raddr_q[9:2]];
    assign axi.rlast   = (rrem_q == 9'd1);
    assign axi.rresp   = rresp_cfg;
    assign axi.rid     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_act <= 1'b0; waddr_q <= '0; raddr_q <= '0; rrem_q <= '0; bvalid_q <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (axi.awvalid && axi.awready) begin
                aw_act  <= 1'b1;
                waddr_q <= axi.awaddr;
            end
            if (axi.wvalid && axi.wready) begin
                for (int b = 0; b < 4; b++)
                    if (axi.wstrb[b]) mem[waddr_q[9:2]][8*b +: 8] <= axi.wdata[8*b +: 8];
                waddr_q <= waddr_q + 16'd4;
                if (axi.wlast) begin
                    aw_act   <= 1'b0;
                    bvalid_q <= 1'b1;
                end
            end
            if (axi.bvalid && axi.bready) bvalid_q <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                raddr_q <= axi.araddr;
                rrem_q  <= {1'b0, axi.arlen} + 9'd1;
            end
            if (axi.rvalid && axi.rready) begin
                raddr_q <= raddr_q + 16'd4;
                rrem_q  <= rrem_q - 9'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    logic [63:0] exp_aw[$], exp_ar[$], exp_w[$], exp_r[$], exp_done[$];
    int wcyc[$];
    logic aw_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event/condition not as required", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected items whenever the DUT completes a transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_seen <= 1'b0;
        end else begin
            if (axi.awvalid && axi.awready) begin
                aw_seen <= 1'b1;
                if (exp_aw.size() == 0) fail("aw_unexpected");
                else check("aw_req", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst}, exp_aw.pop_front());
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else check("ar_req", {axi.araddr, axi.arlen, axi.arsize, axi.arburst}, exp_ar.pop_front());
            end
            if (axi.wvalid && axi.wready) begin
                if (!aw_seen) fail("w_before_aw");
                wcyc.push_back(cyc);
                if (axi.wlast) aw_seen <= 1'b0;
                if (exp_w.size() == 0) fail("w_unexpected");
                else check("w_beat", {axi.wdata, axi.wstrb, axi.wlast}, exp_w.pop_front());
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) fail("r_unexpected");
                else check("r_beat", {rdata, rlast}, exp_r.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) fail("done_unexpected");
                else check("done_resp", resp, exp_done.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] wbuf [0:15];
    logic [3:0]  sbuf [0:15];
    logic [31:0] rbuf [0:15];
    int rdy_seen = 0;

    // All tasks start and end at the drive point (#1 after a rising edge).
    task automatic send_cmd(input logic we, input logic [15:0] addr, input logic [7:0] len);
        int t = 0;
        while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail("cmd_ready_timeout");
        cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic stream_w(input int len);
        int k = 0, t = 0;
        logic hs;
        while (k <= len && t < 100) begin
            wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k];
            @(negedge clk);
            hs = wready && wvalid;
            if (cmd_ready) rdy_seen++;
            @(posedge clk); #1;
            if (hs) k++;
            t++;
        end
        wvalid = 1'b0;
        if (t >= 100) fail("w_stream_timeout");
    endtask

    task automatic stream_r(input bit toggle);
        int t = 0;
        logic last = 1'b0;
        rready = 1'b1;
        while (!last && t < 100) begin
            @(negedge clk);
            last = rvalid && rready && rlast;
            @(posedge clk); #1;
            rready = toggle ? ~rready : 1'b1;
            t++;
        end
        rready = 1'b0;
        if (t >= 100) fail("r_stream_timeout");
    endtask

    task automatic wait_done(output logic rdy_at_done);
        int t = 0;
        logic seen = 1'b0;
        rdy_at_done = 1'b0;
        while (!seen && t < 50) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; rdy_at_done = cmd_ready; end
            else if (cmd_ready) rdy_seen++;
            @(posedge clk); #1;
            t++;
        end
        if (!seen) fail("done_timeout");
    endtask

    task automatic write_op(input logic [15:0] addr, input logic [15:0] exp_addr,
                            input int len, input logic [1:0] exp_resp);
        logic r;
        exp_aw.push_back({exp_addr, 8'(len), 3'd2, 2'b01});
        for (int i = 0; i <= len; i++) exp_w.push_back({wbuf[i], sbuf[i], (i == len)});
        exp_done.push_back(64'(exp_resp));
        send_cmd(1'b1, addr, 8'(len));
        stream_w(len);
        wait_done(r);
    endtask

    task automatic read_op(input logic [15:0] addr, input logic [15:0] exp_addr,
                           input int len, input bit toggle, input logic [1:0] exp_resp);
        logic r;
        exp_ar.push_back({exp_addr, 8'(len), 3'd2, 2'b01});
        for (int i = 0; i <= len; i++) exp_r.push_back({rbuf[i], (i == len)});
        exp_done.push_back(64'(exp_resp));
        send_cmd(1'b0, addr, 8'(len));
        stream_r(toggle);
        wait_done(r);
    endtask

    initial begin
        logic r;
        int k;
        logic hs;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        check("rst_done_resp", {done, resp}, 0);
        check("const_attrs", {axi.awsize, axi.awburst, axi.awcache, axi.awprot, axi.awlock, axi.awqos, axi.awid},
              {3'd2, 2'b01, 4'b0011, 3'b000, 2'b00, 4'b0000, 8'h00});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4-beat write, responder always ready
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        wcyc.delete();
        write_op(16'h0100, 16'h0100, 3, 2'b00);
        check("w_consecutive", (wcyc.size() == 4) ? 64'(wcyc[3] - wcyc[0]) : 64'd99, 3);
        check("write_resp", resp, 2'b00);

        // read back with rready toggling
        rbuf[0] = 32'h11111111; rbuf[1] = 32'h22222222; rbuf[2] = 32'h33333333; rbuf[3] = 32'h44444444;
        read_op(16'h0100, 16'h0100, 3, 1'b1, 2'b00);

        // single-beat unaligned partial-strobe write and readback
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h3;
        write_op(16'h0203, 16'h0200, 0, 2'b00);
        rbuf[0] = 32'h0000CCDD;
        read_op(16'h0200, 16'h0200, 0, 1'b0, 2'b00);

        // error write response, then cleared by next command
        bresp_cfg = 2'b10;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        write_op(16'h0300, 16'h0300, 0, 2'b10);
        check("resp_held", resp, 2'b10);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b01;
        rbuf[0] = 32'h11111111;
        exp_ar.push_back({16'h0100, 8'd0, 3'd2, 2'b01});
        exp_r.push_back({rbuf[0], 1'b1});
        exp_done.push_back(64'(2'b01));
        send_cmd(1'b0, 16'h0100, 8'd0);
        check("resp_cleared", resp, 2'b00);
        stream_r(1'b0);
        wait_done(r);
        rresp_cfg = 2'b00;

        // command held high across a burst
        wbuf[0] = 32'h55555555; wbuf[1] = 32'h66666666; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        exp_aw.push_back({16'h0400, 8'd1, 3'd2, 2'b01});
        exp_w.push_back({wbuf[0], 4'hF, 1'b0});
        exp_w.push_back({wbuf[1], 4'hF, 1'b1});
        exp_done.push_back(64'(2'b00));
        cmd_we = 1'b1; cmd_addr = 16'h0400; cmd_len = 8'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_we = 1'b0;
        rdy_seen = 0;
        stream_w(1);
        wait_done(r);
        check("ready_low_in_burst", rdy_seen, 0);
        check("ready_at_done", r, 1);
        exp_ar.push_back({16'h0400, 8'd1, 3'd2, 2'b01});
        exp_r.push_back({32'h55555555, 1'b0});
        exp_r.push_back({32'h66666666, 1'b1});
        exp_done.push_back(64'(2'b00));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        stream_r(1'b0);
        wait_done(r);

        // reset during beat 2 of a 4-beat write
        wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1;
        exp_aw.push_back({16'h0500, 8'd3, 3'd2, 2'b01});
        exp_w.push_back({wbuf[0], 4'hF, 1'b0});
        send_cmd(1'b1, 16'h0500, 8'd3);
        wvalid = 1'b1; wdata = wbuf[0]; wstrb = 4'hF;
        k = 0;
        hs = 1'b0;
        while (!hs && k < 20) begin
            @(negedge clk); hs = wready;
            @(posedge clk); #1; k++;
        end
        if (!hs) fail("beat1_timeout");
        wdata = wbuf[1];
        #1;
        check("pre_reset_wvalid", axi.wvalid, 1);
        rst_n = 1'b0;
        #1;
        check("async_drop", {axi.awvalid, axi.wvalid, axi.bready}, 0);
        wvalid = 1'b0;
        exp_w.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", {cmd_ready, done, resp}, {1'b1, 1'b0, 2'b00});
        @(posedge clk); #1;
        wbuf[0] = 32'h12345678; wbuf[1] = 32'h9ABCDEF0; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        write_op(16'h0600, 16'h0600, 1, 2'b00);
        rbuf[0] = 32'h12345678; rbuf[1] = 32'h9ABCDEF0;
        read_op(16'h0600, 16'h0600, 1, 1'b0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r.size() + exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
Command-driven AXI4 initiator that executes one INCR burst per command, either a write or a read, against any AXI4 responder such as the on-chip AXI RAM. Write data enters through a valid/ready stream and is forwarded onto the W channel. Read data leaves through a valid/ready stream fed from the R channel. The block is used by test/boot logic and by DMA-style engines to load and inspect AXI memory.

Parameters:
DATA_WIDTH, 32, AXI data bus width in bits (power of two, >= 8)
ADDR_WIDTH, 16, AXI address width in bits
STRB_WIDTH, DATA_WIDTH/8, byte-lane count
ID_WIDTH, 8, AXI ID width
LEN_WIDTH, 8, burst length field width
AXI_ID, 0, constant ID driven on awid/arid

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  block idle, command accepted on valid&ready
cmd_we_i  in  1  1 = write burst, 0 = read burst
cmd_addr_i  in  ADDR_WIDTH  start byte address (low log2(STRB_WIDTH) bits forced to 0)
cmd_len_i  in  LEN_WIDTH  beats minus one
wdata_i / wstrb_i  in  DATA_WIDTH / STRB_WIDTH  write stream payload
wvalid_i  in  1  write stream valid
wready_o  out  1  write stream ready (= axi_wready_i while in W_DATA)
rdata_o  out  DATA_WIDTH  read stream data (= axi_rdata_i)
rvalid_o  out  1  read stream valid (= axi_rvalid_i while in R_DATA)
rready_i  in  1  read stream ready
rlast_o  out  1  last read beat
done_o  out  1  one-cycle pulse at burst completion
resp_o  out  2  worst (max) response of the last burst, held until next command
axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r*  AXI4 master-side channel set, same names and widths as the responder side with _o/_i swapped; awlock/arlock 2 bits

Behaviour:
- Reset: state IDLE; cmd_ready_o=1 (combinational from state); axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o, done_o = 0; resp_o=2'b00; internal addr/len/count = 0.
- Constant outputs: awid/arid=AXI_ID; awsize/arsize=$clog2(STRB_WIDTH); awburst/arburst=2'b01; lock=0, cache=4'b0011, prot=3'b000, qos=0.
- States: IDLE, AW_REQ, W_DATA, B_RESP, AR_REQ, R_DATA.
- IDLE: on cmd_valid_i: latch addr (aligned), len; count<=0; resp_o<=0; go AW_REQ if cmd_we_i else AR_REQ. Next cycle awvalid/arvalid = 1.
- AW_REQ/AR_REQ: addr/len stable from registers; valid held until ready; no deassertion before handshake. On handshake go W_DATA / R_DATA.
- W_DATA: axi_wvalid_o=wvalid_i, axi_wdata/wstrb pass through, wready_o=axi_wready_i, axi_wlast_o=(count==len). Each wvalid&wready beat: count+1. Beat with wlast -> B_RESP. W never precedes AW.
- B_RESP: axi_bready_o=1; on bvalid: resp_o<=bresp, done_o pulse next cycle, -> IDLE.
- R_DATA: axi_rready_o=rready_i, rvalid_o=axi_rvalid_i, rlast_o=axi_rlast_i. Each beat: resp_o<=max(resp_o, rresp). Beat with axi_rlast_i -> IDLE with done_o pulse. Count also tracked; rlast arriving early or late is accepted as given by slave (resp_o unaffected) — completion is rlast-driven.
- Back-pressure: any stall on either stream or channel holds state and count; zero-length burst (len=0) is a single beat with wlast/rlast=1.
- cmd_valid_i in non-IDLE states is ignored (cmd_ready_o=0). Next command accepted the cycle after done_o is asserted... i.e. IDLE re-entry cycle; back-to-back cost: one idle cycle minimum.
- 4 KB boundary crossing is the caller's responsibility; no check.
- Reset mid-burst: all valids drop immediately (async), state IDLE; slave must also be reset.
- Throughput: one beat per cycle when both ends are ready.

Test Plan:
- Write addr=0x0100 len=3, data 0x11111111..0x44444444, wstrb=0xF, responder always ready -> AW addr 0x0100 awlen 3; 4 W beats in 4 consecutive cycles, wlast on 4th; done_o one pulse; resp_o=00.
- Read back addr=0x0100 len=3 with rready_i toggling 1/0 -> rdata_o 0x11111111..0x44444444 in order, rlast_o on 4th beat only, no beat lost or duplicated.
- Single-beat write addr=0x0203 len=0 wstrb=0x3 data 0xAABBCCDD -> awaddr=0x0200, wlast on first beat; readback gives 0x0000CCDD.
- Slave returns bresp=2'b10 -> resp_o=10 after done_o; next command clears resp_o to 00.
- cmd_valid_i held high during an active burst -> second command taken only after done_o, cmd_ready_o=0 throughout burst.
- Assert rst_n_i low during W_DATA beat 2 of 4 -> awvalid/wvalid/bready fall to 0 asynchronously; after release cmd_ready_o=1, new write completes normally.
